// File: rtl/dmni_mem_arbiter_pkg.sv
// Shared types and constants for the DMNI memory-port arbiter.
package dmni_mem_arbiter_pkg;

    // One memory beat as presented by a requester.
    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_req_t;

    // Arbiter FSM states; IDLE performs no memory access, OWNED serves the owner.
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    // Default requester slots.
    localparam int REQ_DMA_RX = 0;
    localparam int REQ_DMA_TX = 1;
    localparam int REQ_MON    = 2;

endpackage

// File: rtl/dmni_mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr_i
// (wrapping at N-1 -> 0) whose request is set and which is not excluded.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    input  logic [N-1:0]         excl_i,
    output logic                 valid_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] cand;

    // Scan N slots starting at the pointer and keep the first eligible one.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr_i) + k) % N);
            if (!valid_o && req_i[cand] && !excl_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/dmni_mem_arbiter.sv
// Owner-based round-robin arbiter sharing the DMNI single memory port among
// N_REQ internal masters, with locked bursts capped at MAX_BURST beats and
// 1-cycle read-data return routed to the issuing requester.
//
// Handshake: req_i[i] offers one beat; the beat is transferred in the cycle
// where gnt_o[i] is high (gnt_o is only ever raised for the registered owner
// while its req_i is high). A requester must hold its beat fields stable until
// granted; dropping req_i without a grant has no side effect.
module dmni_mem_arbiter
    import dmni_mem_arbiter_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int MAX_BURST = 16,
    parameter int ADDR_W    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ-1:0]         lock_i,
    input  logic [N_REQ*4-1:0]       we_i,
    input  logic [N_REQ*ADDR_W-1:0]  addr_i,
    input  logic [N_REQ*32-1:0]      wdata_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [N_REQ-1:0]         rvalid_o,
    output logic [31:0]              rdata_o,
    output logic                     mem_en_o,
    output logic [3:0]               mem_we_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [31:0]              mem_data_o,
    input  logic [31:0]              mem_data_i,
    output logic [$clog2(N_REQ)-1:0] owner_o,
    output logic                     busy_o
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic [IDX_W-1:0]  rd_id_q, rd_id_d;

    logic              own_req, own_lock;
    logic [3:0]        own_we;
    logic [ADDR_W-1:0] own_addr;
    logic [31:0]       own_data;

    logic              owned, beat, forced, rel_own;
    logic [N_REQ-1:0]  excl_mask;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx, pick_next;

    // Select the registered owner's request fields.
    always_comb begin
        own_req  = 1'b0;
        own_lock = 1'b0;
        own_we   = '0;
        own_addr = '0;
        own_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                own_req  = req_i[i];
                own_lock = lock_i[i];
                own_we   = we_i[i*4 +: 4];
                own_addr = addr_i[i*ADDR_W +: ADDR_W];
                own_data = wdata_i[i*32 +: 32];
            end
        end
    end

    assign owned   = (state_q == ARB_OWNED);
    assign beat    = owned && own_req;
    // The cap applies even while lock_i is held.
    assign forced  = beat && (beat_cnt_q == LAST_BEAT);
    assign rel_own = (beat && !own_lock) || (!own_req && !own_lock) || forced;

    // In IDLE every requester competes; on release the current owner steps aside.
    assign excl_mask = owned ? (N_REQ'(1) << owner_q) : '0;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .excl_i  (excl_mask),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign pick_next = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;

    // Next-state logic: ownership hand-over, burst counting, IDLE fallback.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d    = ARB_OWNED;
                    owner_d    = pick_idx;
                    rr_ptr_d   = pick_next;
                    beat_cnt_d = '0;
                end
            end
            ARB_OWNED: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
                if (rel_own) begin
                    beat_cnt_d = '0;
                    if (pick_valid) begin
                        owner_d  = pick_idx;
                        rr_ptr_d = pick_next;
                    end else if (!forced) begin
                        // A forced release with nobody else waiting regrants
                        // the same owner; any other release goes idle.
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Remember read beats so their data can be routed back next cycle.
    always_comb begin
        rd_pend_d = beat && (own_we == 4'b0000);
        rd_id_d   = owner_q;
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            rd_id_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_id_q    <= rd_id_d;
        end
    end

    // Memory port and requester-facing outputs.
    always_comb begin
        gnt_o      = beat ? (N_REQ'(1) << owner_q) : '0;
        mem_en_o   = beat;
        mem_we_o   = beat ? own_we   : '0;
        mem_addr_o = beat ? own_addr : '0;
        mem_data_o = beat ? own_data : '0;
        rvalid_o   = rd_pend_q ? (N_REQ'(1) << rd_id_q) : '0;
        rdata_o    = mem_data_i;
        owner_o    = owner_q;
        busy_o     = owned;
    end

endmodule
